// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM-stage load/store unit with req/ack data-memory bus
// Formats load data, replicates store data across lanes and aborts stuck accesses.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrn_i,
  input  logic [4:0]  wrAddr_i,
  input  logic [31:0] result_i,
  input  logic [7:0]  alu_op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic [5:0]  stall,
  output logic        wrn_o,
  output logic [4:0]  wrAddr_o,
  output logic [31:0] result_o,
  output logic        stallreq_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_sel,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        misalign_o,
  output logic        bus_err_o
);

  localparam logic [7:0] ALU_OP_LB  = 8'h20;
  localparam logic [7:0] ALU_OP_LBU = 8'h21;
  localparam logic [7:0] ALU_OP_LH  = 8'h22;
  localparam logic [7:0] ALU_OP_LHU = 8'h23;
  localparam logic [7:0] ALU_OP_LW  = 8'h24;
  localparam logic [7:0] ALU_OP_SB  = 8'h28;
  localparam logic [7:0] ALU_OP_SH  = 8'h29;
  localparam logic [7:0] ALU_OP_SW  = 8'h2a;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state, state_n;
  logic [7:0]  cnt;
  logic        err_q, first_q, we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  sel_q;

  logic        is_load, is_store, is_mem, is_signed, misaligned;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, load_c, shifted;
  logic        start, take_ack, abort;
  logic        unused;

  assign lane   = mem_addr_i[1:0];
  assign is_mem = is_load | is_store;
  assign unused = ^{stall[5], stall[3:0], shifted[31:16]};

  // size: 0 = byte, 1 = half, 2 = word
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    size      = 2'd0;
    case (alu_op_i)
      ALU_OP_LB:  begin is_load = 1'b1; is_signed = 1'b1; size = 2'd0; end
      ALU_OP_LBU: begin is_load = 1'b1; size = 2'd0; end
      ALU_OP_LH:  begin is_load = 1'b1; is_signed = 1'b1; size = 2'd1; end
      ALU_OP_LHU: begin is_load = 1'b1; size = 2'd1; end
      ALU_OP_LW:  begin is_load = 1'b1; size = 2'd2; end
      ALU_OP_SB:  begin is_store = 1'b1; size = 2'd0; end
      ALU_OP_SH:  begin is_store = 1'b1; size = 2'd1; end
      ALU_OP_SW:  begin is_store = 1'b1; size = 2'd2; end
      default:    ;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    sel_c      = 4'b1111;
    wdata_c    = mem_data_i;
    case (size)
      2'd0: begin
        sel_c   = 4'b0001 << lane;
        wdata_c = {4{mem_data_i[7:0]}};
      end
      2'd1: begin
        misaligned = lane[0];
        sel_c      = lane[1] ? 4'b1100 : 4'b0011;
        wdata_c    = {2{mem_data_i[15:0]}};
      end
      default: misaligned = (lane != 2'd0);
    endcase
  end

  // Inputs are held stable by the stall, so the lane can come straight from mem_addr_i.
  always_comb begin
    shifted = rdata_q >> {lane, 3'b000};
    case (size)
      2'd0:    load_c = is_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
      2'd1:    load_c = is_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
      default: load_c = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    wrn_o      = 1'b0;
    wrAddr_o   = 5'd0;
    result_o   = 32'd0;
    stallreq_o = 1'b0;
    dmem_req   = 1'b0;
    misalign_o = 1'b0;
    bus_err_o  = 1'b0;
    start      = 1'b0;
    take_ack   = 1'b0;
    abort      = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          wrAddr_o = wrAddr_i;
          if (!is_mem) begin
            wrn_o    = wrn_i;
            result_o = result_i;
          end else if (misaligned) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o = 1'b1;
            start      = 1'b1;
            state_n    = S_WAIT;
          end
        end
        S_WAIT: begin
          dmem_req   = 1'b1;
          stallreq_o = 1'b1;
          if (dmem_ack) begin
            take_ack = 1'b1;
            state_n  = S_DONE;
          end else if (cnt == CNT_LAST) begin
            abort   = 1'b1;
            state_n = S_DONE;
          end
        end
        S_DONE: begin
          wrAddr_o = wrAddr_i;
          if (err_q) begin
            bus_err_o = first_q;
          end else begin
            wrn_o    = wrn_i;
            result_o = is_load ? load_c : result_i;
          end
          if (!stall[4]) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 8'd0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      sel_q   <= 4'd0;
    end else begin
      first_q <= (state_n == S_DONE) && (state != S_DONE);
      if (start) begin
        addr_q  <= {mem_addr_i[31:2], 2'b00};
        sel_q   <= sel_c;
        we_q    <= is_store;
        wdata_q <= wdata_c;
        cnt     <= 8'd0;
        err_q   <= 1'b0;
      end else if (state == S_WAIT) begin
        cnt <= cnt + 8'd1;
      end
      if (take_ack) rdata_q <= dmem_rdata;
      if (abort)    err_q   <= 1'b1;
    end
  end

  assign dmem_we    = rst ? 1'b0  : we_q;
  assign dmem_addr  = rst ? 32'd0 : addr_q;
  assign dmem_sel   = rst ? 4'd0  : sel_q;
  assign dmem_wdata = rst ? 32'd0 : wdata_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - bench for mem_access
// Fixed vectors, a behavioural model for random ops, and reset/hold sequences.
module tb_mem_access;
  localparam int TO = 4;
  localparam logic [7:0] OP_NOP = 8'h01, OP_LB = 8'h20, OP_LBU = 8'h21, OP_LH = 8'h22,
                         OP_LHU = 8'h23, OP_LW = 8'h24, OP_SB = 8'h28, OP_SH = 8'h29, OP_SW = 8'h2a;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrn_i;
  logic [4:0]  wrAddr_i;
  logic [31:0] result_i;
  logic [7:0]  alu_op_i;
  logic [31:0] mem_addr_i, mem_data_i;
  logic [5:0]  stall;
  logic        wrn_o;
  logic [4:0]  wrAddr_o;
  logic [31:0] result_o;
  logic        stallreq_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_sel;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack, misalign_o, bus_err_o;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .wrn_i(wrn_i), .wrAddr_i(wrAddr_i), .result_i(result_i),
    .alu_op_i(alu_op_i), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .stall(stall),
    .wrn_o(wrn_o), .wrAddr_o(wrAddr_o), .result_o(result_o), .stallreq_o(stallreq_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_sel(dmem_sel),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr, wd, rd;
    int          waits;
    logic [31:0] e_res;
    logic        e_wrn;
    int          e_stall, e_req;
    logic [3:0]  e_sel;
    logic        e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_mis, e_berr;
  } vec_t;

  typedef struct {
    int          n_stall, n_req;
    logic [31:0] res;
    logic        wrn;
    logic [4:0]  wa;
    logic        mis, berr;
    logic [31:0] baddr;
    logic [3:0]  bsel;
    logic        bwe;
    logic [31:0] bwd;
    logic        stable, done;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // waits = extra wait cycles before ack; negative means the bus never acks.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int waits, output obs_t o);
    bit seen = 0;
    o = '{0, 0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 32'd0, 1'b1, 1'b0};
    alu_op_i   = op;
    mem_addr_i = addr;
    mem_data_i = wd;
    for (int c = 0; c < TO + 12; c++) begin
      @(negedge clk);
      if (stallreq_o) o.n_stall++;
      if (misalign_o) o.mis = 1'b1;
      if (dmem_req) begin
        if (!seen) begin
          o.baddr = dmem_addr; o.bsel = dmem_sel; o.bwe = dmem_we; o.bwd = dmem_wdata;
        end else if (dmem_addr !== o.baddr || dmem_sel !== o.bsel || dmem_we !== o.bwe ||
                     dmem_wdata !== o.bwd) begin
          o.stable = 1'b0;
        end
        seen = 1;
        o.n_req++;
        if (waits >= 0 && o.n_req == waits + 1) begin
          dmem_ack = 1'b1; dmem_rdata = rd;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
      end else begin
        dmem_ack = 1'b0;
        if (seen || !stallreq_o) begin
          o.res = result_o; o.wrn = wrn_o; o.wa = wrAddr_o; o.berr = bus_err_o; o.done = 1'b1;
          break;
        end
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    alu_op_i = OP_NOP;
  endtask

  // Reference: byte counts, lane arithmetic and replication by multiplication.
  task automatic model(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int waits, output vec_t e);
    int nbytes = 0;
    bit ld = 0, st = 0, sgn = 0;
    int lane;
    logic [63:0] v;
    case (op)
      OP_LB:  begin nbytes = 1; ld = 1; sgn = 1; end
      OP_LBU: begin nbytes = 1; ld = 1; end
      OP_LH:  begin nbytes = 2; ld = 1; sgn = 1; end
      OP_LHU: begin nbytes = 2; ld = 1; end
      OP_LW:  begin nbytes = 4; ld = 1; end
      OP_SB:  begin nbytes = 1; st = 1; end
      OP_SH:  begin nbytes = 2; st = 1; end
      OP_SW:  begin nbytes = 4; st = 1; end
      default: nbytes = 0;
    endcase
    lane = int'(addr % 4);
    e = '{op, addr, wd, rd, waits, result_i, wrn_i, 0, 0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0};
    if (nbytes == 0) return;
    if (lane % nbytes != 0) begin
      e.e_res = 32'd0; e.e_wrn = 1'b0; e.e_mis = 1'b1;
      return;
    end
    e.e_req   = (waits < 0) ? TO : waits + 1;
    e.e_stall = e.e_req + 1;
    e.e_sel   = 4'(((1 << nbytes) - 1) << lane);
    e.e_we    = st;
    e.e_addr  = addr - 32'(lane);
    e.e_wd    = (nbytes == 1) ? (wd & 32'hff) * 32'h01010101 :
                (nbytes == 2) ? (wd & 32'hffff) * 32'h00010001 : wd;
    if (waits < 0) begin
      e.e_res = 32'd0; e.e_wrn = 1'b0; e.e_berr = 1'b1;
    end else if (ld) begin
      v = (64'(rd) >> (8 * lane)) & ((64'd1 << (8 * nbytes)) - 64'd1);
      if (sgn && v >= (64'd1 << (8 * nbytes - 1))) v = v - (64'd1 << (8 * nbytes));
      e.e_res = v[31:0];
    end
  endtask

  task automatic compare(input string tag, input vec_t e, input obs_t o);
    chk({tag, "_done"},   32'(o.done), 32'd1);
    chk({tag, "_result"}, o.res, e.e_res);
    chk({tag, "_wrn"},    32'(o.wrn), 32'(e.e_wrn));
    chk({tag, "_wraddr"}, 32'(o.wa), 32'(wrAddr_i));
    chk({tag, "_stall"},  32'(o.n_stall), 32'(e.e_stall));
    chk({tag, "_req"},    32'(o.n_req), 32'(e.e_req));
    chk({tag, "_mis"},    32'(o.mis), 32'(e.e_mis));
    chk({tag, "_berr"},   32'(o.berr), 32'(e.e_berr));
    if (e.e_req > 0) begin
      chk({tag, "_addr"},   o.baddr, e.e_addr);
      chk({tag, "_sel"},    32'(o.bsel), 32'(e.e_sel));
      chk({tag, "_we"},     32'(o.bwe), 32'(e.e_we));
      chk({tag, "_stable"}, 32'(o.stable), 32'd1);
      if (e.e_we) chk({tag, "_wdata"}, o.bwd, e.e_wd);
    end
  endtask

  vec_t tbl[13];
  logic [7:0] ops[9] = '{OP_NOP, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

  initial begin
    obs_t o;
    vec_t e;
    int nreq;

    tbl[0]  = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 0,  32'hDEADBEEF, 1, 2, 1, 4'hF, 0, 32'h100, 32'h0,        0, 0};
    tbl[1]  = '{OP_LB,  32'h102, 32'h0,        32'h00800000, 0,  32'hFFFFFF80, 1, 2, 1, 4'h4, 0, 32'h100, 32'h0,        0, 0};
    tbl[2]  = '{OP_LBU, 32'h102, 32'h0,        32'h00800000, 1,  32'h00000080, 1, 3, 2, 4'h4, 0, 32'h100, 32'h0,        0, 0};
    tbl[3]  = '{OP_SH,  32'h206, 32'h1234ABCD, 32'h0,        3,  32'h5555AAAA, 1, 5, 4, 4'hC, 1, 32'h204, 32'hABCDABCD, 0, 0};
    tbl[4]  = '{OP_LW,  32'h102, 32'h0,        32'h0,        0,  32'h0,        0, 0, 0, 4'h0, 0, 32'h0,   32'h0,        1, 0};
    tbl[5]  = '{OP_NOP, 32'h0,   32'h0,        32'h0,        0,  32'h5555AAAA, 1, 0, 0, 4'h0, 0, 32'h0,   32'h0,        0, 0};
    tbl[6]  = '{OP_LH,  32'h106, 32'h0,        32'h80011234, 0,  32'hFFFF8001, 1, 2, 1, 4'hC, 0, 32'h104, 32'h0,        0, 0};
    tbl[7]  = '{OP_LHU, 32'h104, 32'h0,        32'h8001F234, 0,  32'h0000F234, 1, 2, 1, 4'h3, 0, 32'h104, 32'h0,        0, 0};
    tbl[8]  = '{OP_SB,  32'h203, 32'h0000005A, 32'h0,        2,  32'h5555AAAA, 1, 4, 3, 4'h8, 1, 32'h200, 32'h5A5A5A5A, 0, 0};
    tbl[9]  = '{OP_LW,  32'h300, 32'h0,        32'h0,        -1, 32'h0,        0, 5, 4, 4'hF, 0, 32'h300, 32'h0,        0, 1};
    tbl[10] = '{OP_SH,  32'h201, 32'h0,        32'h0,        0,  32'h0,        0, 0, 0, 4'h0, 0, 32'h0,   32'h0,        1, 0};
    tbl[11] = '{OP_SW,  32'h10C, 32'hCAFEF00D, 32'h0,        0,  32'h5555AAAA, 1, 2, 1, 4'hF, 1, 32'h10C, 32'hCAFEF00D, 0, 0};
    tbl[12] = '{OP_LB,  32'h103, 32'h0,        32'h7F000000, 0,  32'h0000007F, 1, 2, 1, 4'h8, 0, 32'h100, 32'h0,        0, 0};

    rst = 1'b1; wrn_i = 1'b1; wrAddr_i = 5'd7; result_i = 32'h5555AAAA;
    alu_op_i = OP_NOP; mem_addr_i = 32'h0; mem_data_i = 32'h0; stall = 6'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wrn", 32'(wrn_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_stallreq", 32'(stallreq_o), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].waits, o);
      compare($sformatf("vec%0d", i), tbl[i], o);
    end

    // Reset in the middle of WAIT, then a late ack that must be ignored.
    alu_op_i = OP_LW; mem_addr_i = 32'h100;
    @(negedge clk);
    @(negedge clk);
    chk("rstw_req_before", 32'(dmem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_req_in_rst", 32'(dmem_req), 32'd0);
    chk("rstw_stall_in_rst", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; alu_op_i = OP_NOP; result_i = 32'h11111111;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rstw_req_after", 32'(dmem_req), 32'd0);
    chk("rstw_stall_after", 32'(stallreq_o), 32'd0);
    chk("rstw_berr_after", 32'(bus_err_o), 32'd0);
    chk("rstw_idle_pass", result_o, 32'h11111111);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("rstw_req_later", 32'(dmem_req), 32'd0);
    chk("rstw_berr_later", 32'(bus_err_o), 32'd0);
    @(posedge clk); #1;

    // Timeout while MEM/WB is held: error pulse on the first DONE cycle only.
    result_i = 32'h5555AAAA; stall = 6'b010000;
    alu_op_i = OP_LW; mem_addr_i = 32'h300;
    nreq = 0;
    for (int c = 0; c < TO + 1; c++) begin
      @(negedge clk);
      if (dmem_req) nreq++;
    end
    chk("hold_req_cycles", 32'(nreq), 32'(TO));
    @(negedge clk);
    chk("hold_done1_berr", 32'(bus_err_o), 32'd1);
    chk("hold_done1_req", 32'(dmem_req), 32'd0);
    chk("hold_done1_wrn", 32'(wrn_o), 32'd0);
    chk("hold_done1_result", result_o, 32'd0);
    @(negedge clk);
    chk("hold_done2_berr", 32'(bus_err_o), 32'd0);
    chk("hold_done2_req", 32'(dmem_req), 32'd0);
    chk("hold_done2_stall", 32'(stallreq_o), 32'd0);
    chk("hold_done2_result", result_o, 32'd0);
    @(posedge clk); #1;
    stall = 6'd0; alu_op_i = OP_NOP;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_back_idle", result_o, 32'h5555AAAA);
    chk("hold_back_wrn", 32'(wrn_o), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      logic [7:0]  op;
      logic [31:0] addr, wd, rd;
      int          waits;
      op       = ops[$urandom_range(0, 8)];
      addr     = $urandom & 32'h0000_0FFF;
      wd       = $urandom;
      rd       = $urandom;
      waits    = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      result_i = $urandom;
      wrn_i    = 1'($urandom_range(0, 1));
      wrAddr_i = 5'($urandom_range(0, 31));
      model(op, addr, wd, rd, waits, e);
      run_op(op, addr, wd, rd, waits, o);
      compare($sformatf("rnd%0d", i), e, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
